bidir_dir_ctrl: RTL and testbench

BIDIR_DIR_CTRL -- requirements
Module: bidir_dir_ctrl

---
 rtl/bidir_dir_ctrl.sv | 148 ++++++++++++++
 tb/tb_bidir_dir_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bidir_dir_ctrl.sv
// Half-duplex bus direction controller: arbitrates side A/B words onto a shared bus
// with dead turnaround cycles and a burst limit. Optional counters: BIDIR_DIR_CTRL_STATS_EN.
module bidir_dir_ctrl #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned TURN_CYC  = 2,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_req,
   input  logic             b_req,
   input  logic [WIDTH-1:0] a_data,
   input  logic [WIDTH-1:0] b_data,
   output logic             a_gnt,
   output logic             b_gnt,
   output logic             sel,
   output logic             oe,
   output logic [WIDTH-1:0] bus_data,
   output logic             bus_valid
`ifdef BIDIR_DIR_CTRL_STATS_EN
   ,
   output logic [15:0]      a_xfer_cnt,
   output logic [15:0]      b_xfer_cnt,
   output logic [15:0]      turn_cnt_total
`endif
);

   localparam int unsigned CW = 4;
   localparam int unsigned SW = 16;

   typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_e;

   state_e           state_q, state_d;
   logic             sel_q, sel_d;
   logic             oe_q, oe_d;
   logic             a_gnt_q, a_gnt_d;
   logic             b_gnt_q, b_gnt_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    burst_q, burst_d;
   logic [CW-1:0]    turn_q, turn_d;

   logic             s_req, o_req, grant_c, turn_c;
   logic [WIDTH-1:0] s_data;

   // Requests seen relative to the side currently owning the bus.
   always_comb begin
      s_req   = sel_q ? a_req  : b_req;
      o_req   = sel_q ? b_req  : a_req;
      s_data  = sel_q ? a_data : b_data;
      grant_c = (state_q == IDLE) && s_req && ((burst_q < CW'(BURST_MAX)) || !o_req);
      turn_c  = (state_q == IDLE) && o_req && (!s_req || (burst_q == CW'(BURST_MAX)));
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 1'b1;
         oe_q    <= 1'b0;
         a_gnt_q <= 1'b0;
         b_gnt_q <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         burst_q <= '0;
         turn_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         oe_q    <= oe_d;
         a_gnt_q <= a_gnt_d;
         b_gnt_q <= b_gnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         burst_q <= burst_d;
         turn_q  <= turn_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_c)     state_d = DRIVE;
            else if (turn_c) state_d = TURN;
         end
         DRIVE:   state_d = IDLE;
         TURN:    if (turn_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      sel_d   = sel_q;
      oe_d    = 1'b0;
      a_gnt_d = 1'b0;
      b_gnt_d = 1'b0;
      valid_d = 1'b0;
      data_d  = data_q;
      burst_d = burst_q;
      turn_d  = turn_q;
      if (grant_c) begin
         a_gnt_d = sel_q;
         b_gnt_d = !sel_q;
         valid_d = 1'b1;
         oe_d    = 1'b1;
         data_d  = s_data;
         if (burst_q != CW'(BURST_MAX)) burst_d = burst_q + CW'(1);
      end
      if (turn_c) begin
         sel_d   = !sel_q;
         burst_d = '0;
         turn_d  = CW'(TURN_CYC - 1);
      end
      if ((state_q == TURN) && (turn_q != '0)) turn_d = turn_q - CW'(1);
   end

   assign sel       = sel_q;
   assign oe        = oe_q;
   assign a_gnt     = a_gnt_q;
   assign b_gnt     = b_gnt_q;
   assign bus_valid = valid_q;
   assign bus_data  = data_q;

`ifdef BIDIR_DIR_CTRL_STATS_EN
   logic [SW-1:0] a_cnt_q, b_cnt_q, t_cnt_q;

   // Free-running wrap-around statistics.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_cnt_q <= '0;
         b_cnt_q <= '0;
         t_cnt_q <= '0;
      end else begin
         if (grant_c && sel_q)  a_cnt_q <= a_cnt_q + SW'(1);
         if (grant_c && !sel_q) b_cnt_q <= b_cnt_q + SW'(1);
         if (turn_c)            t_cnt_q <= t_cnt_q + SW'(1);
      end
   end

   assign a_xfer_cnt     = a_cnt_q;
   assign b_xfer_cnt     = b_cnt_q;
   assign turn_cnt_total = t_cnt_q;
`endif

endmodule

// File: tb/tb_bidir_dir_ctrl.sv
// Self-checking bench for bidir_dir_ctrl (WIDTH=8, TURN_CYC=2, BURST_MAX=4): vector table
// through a scoreboard queue, then a continuous two-sided burst sequence.
module tb_bidir_dir_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_req, b_req;
   logic [7:0] a_data, b_data;
   logic       a_gnt, b_gnt, sel, oe, bus_valid;
   logic [7:0] bus_data;
`ifdef BIDIR_DIR_CTRL_STATS_EN
   logic [15:0] a_xfer_cnt, b_xfer_cnt, turn_cnt_total;
`endif

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   bidir_dir_ctrl #(.WIDTH(8), .TURN_CYC(2), .BURST_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .b_req(b_req), .a_data(a_data), .b_data(b_data),
      .a_gnt(a_gnt), .b_gnt(b_gnt), .sel(sel), .oe(oe),
      .bus_data(bus_data), .bus_valid(bus_valid)
`ifdef BIDIR_DIR_CTRL_STATS_EN
      , .a_xfer_cnt(a_xfer_cnt), .b_xfer_cnt(b_xfer_cnt), .turn_cnt_total(turn_cnt_total)
`endif
   );

   // exp = {a_gnt, b_gnt, sel, oe, bus_valid, bus_data} after the edge
   typedef struct {
      logic        rst_n;
      logic        a_req;
      logic [7:0]  a_data;
      logic        b_req;
      logic [7:0]  b_data;
      logic [12:0] exp;
   } vec_t;

   typedef struct {
      logic       side_a;
      logic [7:0] data;
      int         gap;
   } gexp_t;

   vec_t        vecs[$];
   logic [12:0] sb_q[$];
   gexp_t       gq[$];

   function automatic vec_t v(input logic r, input logic ar, input logic [7:0] ad,
                              input logic br, input logic [7:0] bd,
                              input logic ag, input logic bg, input logic s,
                              input logic o, input logic [7:0] d);
      vec_t t;
      t.rst_n = r; t.a_req = ar; t.a_data = ad; t.b_req = br; t.b_data = bd;
      t.exp   = {ag, bg, s, o, ag | bg, d};
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic apply(input int idx, input vec_t t);
      logic [12:0] e;
      @(negedge clk);
      rst_n = t.rst_n; a_req = t.a_req; a_data = t.a_data;
      b_req = t.b_req; b_data = t.b_data;
      sb_q.push_back(t.exp);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check($sformatf("vec%0d {ag,bg,sel,oe,vld,data}", idx),
            32'({a_gnt, b_gnt, sel, oe, bus_valid, bus_data}), 32'(e));
   endtask

   initial begin
      int   gap, ncyc;
      logic prev_sel, prev_oe;
      gexp_t g;

      rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; a_data = '0; b_data = '0;

      //               rst ar ad     br bd     ag bg sel oe data
      vecs.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00));
      vecs.push_back(v(1, 1, 8'h5A, 0, 8'h00, 1, 0, 1, 1, 8'h5A));
      vecs.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h5A));
      vecs.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h5A));
      vecs.push_back(v(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00));
      vecs.push_back(v(1, 0, 8'h00, 1, 8'hC3, 0, 0, 0, 0, 8'h00));
      vecs.push_back(v(1, 0, 8'h00, 1, 8'hC3, 0, 0, 0, 0, 8'h00));
      vecs.push_back(v(1, 0, 8'h00, 1, 8'hC3, 0, 0, 0, 0, 8'h00));
      vecs.push_back(v(1, 0, 8'h00, 1, 8'hC3, 0, 1, 0, 1, 8'hC3));
      vecs.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'hC3));
      vecs.push_back(v(1, 1, 8'h11, 0, 8'h00, 0, 0, 1, 0, 8'hC3));
      vecs.push_back(v(1, 1, 8'h11, 0, 8'h00, 0, 0, 1, 0, 8'hC3));
      vecs.push_back(v(1, 1, 8'h11, 0, 8'h00, 0, 0, 1, 0, 8'hC3));
      vecs.push_back(v(1, 1, 8'h11, 0, 8'h00, 1, 0, 1, 1, 8'h11));
      vecs.push_back(v(0, 1, 8'h11, 0, 8'h00, 0, 0, 1, 0, 8'h00)); // reset in DRIVE
      vecs.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00));
      vecs.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00));
      vecs.push_back(v(1, 0, 8'h00, 1, 8'h77, 0, 0, 0, 0, 8'h00)); // B withdraws in TURN
      vecs.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00));
      vecs.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00));
      vecs.push_back(v(1, 1, 8'h22, 0, 8'h00, 0, 0, 1, 0, 8'h00));
      vecs.push_back(v(1, 1, 8'h22, 0, 8'h00, 0, 0, 1, 0, 8'h00));
      vecs.push_back(v(1, 1, 8'h22, 0, 8'h00, 0, 0, 1, 0, 8'h00));
      vecs.push_back(v(1, 1, 8'h22, 0, 8'h00, 1, 0, 1, 1, 8'h22));
      vecs.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h22));
      vecs.push_back(v(1, 1, 8'h31, 0, 8'h00, 1, 0, 1, 1, 8'h31)); // unopposed A past limit
      vecs.push_back(v(1, 1, 8'h31, 0, 8'h00, 0, 0, 1, 0, 8'h31));
      vecs.push_back(v(1, 1, 8'h32, 0, 8'h00, 1, 0, 1, 1, 8'h32));
      vecs.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h32));
      vecs.push_back(v(1, 1, 8'h33, 0, 8'h00, 1, 0, 1, 1, 8'h33));
      vecs.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h33));
      vecs.push_back(v(1, 1, 8'h34, 0, 8'h00, 1, 0, 1, 1, 8'h34));
      vecs.push_back(v(1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h34));
      vecs.push_back(v(1, 1, 8'h35, 1, 8'h44, 0, 0, 0, 0, 8'h34)); // burst saturated -> turn
      vecs.push_back(v(1, 0, 8'h00, 1, 8'h44, 0, 0, 0, 0, 8'h34));
      vecs.push_back(v(1, 0, 8'h00, 1, 8'h44, 0, 0, 0, 0, 8'h34));
      vecs.push_back(v(1, 0, 8'h00, 1, 8'h44, 0, 1, 0, 1, 8'h44));

      for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

      // Continuous contention: AAAA, 4 idle cycles, BBBB, ...
      apply(vecs.size(), v(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h00));
      for (int i = 0; i < 16; i++) begin
         g.side_a = ((i / 4) % 2) == 0;
         g.data   = g.side_a ? 8'hA1 : 8'hB2;
         g.gap    = (i == 0) ? -1 : ((i % 4) == 0 ? 4 : 1);
         gq.push_back(g);
      end
      @(negedge clk);
      rst_n = 1'b1; a_req = 1'b1; b_req = 1'b1; a_data = 8'hA1; b_data = 8'hB2;
      prev_sel = sel; prev_oe = oe; gap = 0; ncyc = 0;
      while (gq.size() != 0 && ncyc < 80) begin
         @(posedge clk);
         #1;
         ncyc++;
         check("gnt exclusive / valid==gnt",
               32'({a_gnt & b_gnt, bus_valid ^ (a_gnt | b_gnt)}), 32'd0);
         if (sel !== prev_sel && (oe || prev_oe))
            check("sel changed with oe high", 32'(sel), 32'(prev_sel));
         if (a_gnt || b_gnt) begin
            g = gq.pop_front();
            check("burst grant side", 32'(a_gnt), 32'(g.side_a));
            check("burst grant data", 32'(bus_data), 32'(g.data));
            if (g.gap >= 0) check("burst idle gap", 32'(gap), 32'(g.gap));
            gap = 0;
         end else begin
            gap++;
         end
         prev_sel = sel; prev_oe = oe;
      end
      check("burst grants outstanding (timeout)", 32'(gq.size()), 32'd0);
`ifdef BIDIR_DIR_CTRL_STATS_EN
      check("a_xfer_cnt", 32'(a_xfer_cnt), 32'd8);
      check("b_xfer_cnt", 32'(b_xfer_cnt), 32'd8);
      check("turn_cnt_total", 32'(turn_cnt_total), 32'd3);
`endif
      @(negedge clk);
      a_req = 1'b0; b_req = 1'b0;
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
